// File: rtl/mod_dmem_port.sv
// MEM-stage data port: fetches the 64B line for a load or store, extracts 8 bytes or read-modify-writes the line.
// Latency: load_done visible in the 11th cycle of an unstalled load; a store adds a merge cycle plus 9 write words.
// Backpressure: each request word is held until bus_reqack; RD_TAG response beats are always acked, others never.
module mod_dmem_port #(
    parameter int              BEATS  = 8,
    parameter int              TAGW   = 13,
    parameter logic [TAGW-1:0] RD_TAG = 13'h1100,
    parameter logic [TAGW-1:0] WR_TAG = 13'h0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            data_reqFlag,
    input  logic [63:0]     data_reqAddr,
    input  logic            store_reqFlag,
    input  logic [63:0]     store_reqAddr,
    input  logic [63:0]     store_data,
    output logic            load_done,
    output logic [63:0]     load_buffer,
    output logic            store_opn,
    output logic            err,
    output logic            bus_reqcyc,
    output logic [63:0]     bus_req,
    output logic [TAGW-1:0] bus_reqtag,
    input  logic            bus_reqack,
    input  logic            bus_respcyc,
    input  logic [63:0]     bus_resp,
    input  logic [TAGW-1:0] bus_resptag,
    output logic            bus_respack
);
    localparam int LINEW = 64 * BEATS;
    localparam int IW    = $clog2(LINEW);
    localparam int OW    = IW - 3;
    localparam int CW    = $clog2(BEATS);
    localparam logic [OW-1:0] OFF_MAX  = OW'(8 * BEATS - 8);
    localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_RESP = 3'd2;
    localparam logic [2:0] MERGE   = 3'd3;
    localparam logic [2:0] WR_REQ  = 3'd4;
    localparam logic [2:0] WR_DATA = 3'd5;
    localparam logic [2:0] LD_DONE = 3'd6;
    localparam logic [2:0] ST_DONE = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [63:0]      addr_q, addr_d;
    logic [63:0]      sdata_q, sdata_d;
    logic             is_store_q, is_store_d;
    logic [LINEW-1:0] line_q, line_d;
    logic             load_done_q, load_done_d;
    logic [63:0]      load_buffer_q, load_buffer_d;
    logic             store_opn_q, store_opn_d;
    logic             err_q, err_d;
    logic             bus_reqcyc_q, bus_reqcyc_d;
    logic [63:0]      bus_req_q, bus_req_d;
    logic [TAGW-1:0]  bus_reqtag_q, bus_reqtag_d;
    logic [CW-1:0]    cnt_inc;

    function automatic logic [63:0] line_addr(input logic [63:0] a);
        return {a[63:OW], {OW{1'b0}}};
    endfunction

    function automatic logic [63:0] extract(input logic [LINEW-1:0] ln, input logic [OW-1:0] off);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = ln[IW'({off, 3'b000}) + IW'(8 * i) +: 8];
        return r;
    endfunction

    function automatic logic [LINEW-1:0] merge(input logic [LINEW-1:0] ln, input logic [OW-1:0] off,
                                               input logic [63:0] d);
        logic [LINEW-1:0] r;
        r = ln;
        for (int i = 0; i < 8; i++) r[IW'({off, 3'b000}) + IW'(8 * i) +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Matching beats are acked in every state so stale read data drains after a reset.
    assign bus_respack = bus_respcyc && (bus_resptag == RD_TAG);
    assign cnt_inc     = cnt_q + CNT_ONE;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        sdata_d       = sdata_q;
        is_store_d    = is_store_q;
        line_d        = line_q;
        load_done_d   = load_done_q;
        load_buffer_d = load_buffer_q;
        store_opn_d   = store_opn_q;
        err_d         = err_q;
        bus_reqcyc_d  = bus_reqcyc_q;
        bus_req_d     = bus_req_q;
        bus_reqtag_d  = bus_reqtag_q;
        case (state_q)
            IDLE: begin
                if (data_reqFlag) begin
                    addr_d     = data_reqAddr;
                    is_store_d = 1'b0;
                    if (data_reqAddr[OW-1:0] > OFF_MAX) begin
                        err_d         = 1'b1;
                        load_done_d   = 1'b1;
                        load_buffer_d = '0;
                        state_d       = LD_DONE;
                    end else begin
                        bus_reqcyc_d = 1'b1;
                        bus_req_d    = line_addr(data_reqAddr);
                        bus_reqtag_d = RD_TAG;
                        state_d      = RD_REQ;
                    end
                end else if (store_reqFlag) begin
                    addr_d     = store_reqAddr;
                    sdata_d    = store_data;
                    is_store_d = 1'b1;
                    if (store_reqAddr[OW-1:0] > OFF_MAX) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        store_opn_d  = 1'b1;
                        bus_reqcyc_d = 1'b1;
                        bus_req_d    = line_addr(store_reqAddr);
                        bus_reqtag_d = RD_TAG;
                        state_d      = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (bus_reqack) begin
                    bus_reqcyc_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = RD_RESP;
                end
            end
            RD_RESP: begin
                if (bus_respack) begin
                    line_d[{cnt_q, 6'b000000} +: 64] = bus_resp;
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_LAST) begin
                        if (is_store_q) begin
                            state_d = MERGE;
                        end else begin
                            load_done_d   = 1'b1;
                            load_buffer_d = extract(line_d, addr_q[OW-1:0]);
                            state_d       = LD_DONE;
                        end
                    end
                end
            end
            MERGE: begin
                line_d       = merge(line_q, addr_q[OW-1:0], sdata_q);
                bus_reqcyc_d = 1'b1;
                bus_req_d    = line_addr(addr_q);
                bus_reqtag_d = WR_TAG;
                state_d      = WR_REQ;
            end
            WR_REQ: begin
                if (bus_reqack) begin
                    cnt_d     = '0;
                    bus_req_d = line_q[63:0];
                    state_d   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (bus_reqack) begin
                    if (cnt_q == CNT_LAST) begin
                        bus_reqcyc_d = 1'b0;
                        store_opn_d  = 1'b0;
                        state_d      = ST_DONE;
                    end else begin
                        cnt_d     = cnt_inc;
                        bus_req_d = line_q[{cnt_inc, 6'b000000} +: 64];
                    end
                end
            end
            LD_DONE: begin
                if (!data_reqFlag) begin
                    load_done_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                if (!store_reqFlag) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            sdata_q       <= '0;
            is_store_q    <= 1'b0;
            line_q        <= '0;
            load_done_q   <= 1'b0;
            load_buffer_q <= '0;
            store_opn_q   <= 1'b0;
            err_q         <= 1'b0;
            bus_reqcyc_q  <= 1'b0;
            bus_req_q     <= '0;
            bus_reqtag_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            sdata_q       <= sdata_d;
            is_store_q    <= is_store_d;
            line_q        <= line_d;
            load_done_q   <= load_done_d;
            load_buffer_q <= load_buffer_d;
            store_opn_q   <= store_opn_d;
            err_q         <= err_d;
            bus_reqcyc_q  <= bus_reqcyc_d;
            bus_req_q     <= bus_req_d;
            bus_reqtag_q  <= bus_reqtag_d;
        end
    end

    assign load_done   = load_done_q;
    assign load_buffer = load_buffer_q;
    assign store_opn   = store_opn_q;
    assign err         = err_q;
    assign bus_reqcyc  = bus_reqcyc_q;
    assign bus_req     = bus_req_q;
    assign bus_reqtag  = bus_reqtag_q;
endmodule

// File: tb/tb_mod_dmem_port.sv
// Bench for mod_dmem_port: table of load/store vectors plus hand sequences for latency, arbitration and reset drain.
// A bus model serves line reads and checks every accepted request word against a scoreboard queue.
module tb_mod_dmem_port;
    localparam logic [12:0] RD_TAG = 13'h1100;
    localparam logic [12:0] WR_TAG = 13'h0100;
    localparam logic [63:0] PAT1   = 64'h1111_1111_1111_1111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_reqFlag = 1'b0, store_reqFlag = 1'b0;
    logic [63:0] data_reqAddr = '0, store_reqAddr = '0, store_data = '0;
    logic        load_done, store_opn, err, bus_reqcyc, bus_respack;
    logic [63:0] load_buffer, bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack = 1'b0, bus_respcyc = 1'b0;
    logic [63:0] bus_resp = '0;
    logic [12:0] bus_resptag = '0;

    always #5 clk = ~clk;

    mod_dmem_port dut (
        .clk(clk), .reset(reset),
        .data_reqFlag(data_reqFlag), .data_reqAddr(data_reqAddr),
        .store_reqFlag(store_reqFlag), .store_reqAddr(store_reqAddr), .store_data(store_data),
        .load_done(load_done), .load_buffer(load_buffer), .store_opn(store_opn), .err(err),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
    );

    typedef struct {
        logic [63:0] addr;
        logic        is_store;
        logic [63:0] sdata;
        logic [63:0] base;
        logic [63:0] step;
        logic        exp_err;
        logic [63:0] exp_buf;
    } vec_t;
    typedef struct packed { logic [12:0] tag; logic [63:0] dat; } word_t;

    int          n_tests = 0, n_fail = 0;
    logic [63:0] mem_line [8];
    word_t       exp_q [$];
    logic [63:0] resp_q [$];
    bit          no_stall = 1'b0;
    int          reqcyc_cycles = 0;
    int          beats_driven = 0;
    vec_t        vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] line_of();
        logic [511:0] r;
        for (int k = 0; k < 8; k++) r[64*k +: 64] = mem_line[k];
        return r;
    endfunction

    function automatic logic [511:0] merge_model(input logic [511:0] ln, input int off, input logic [63:0] d);
        logic [511:0] r;
        r = ln;
        for (int i = 0; i < 8; i++) r[8*(off+i) +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic push_store_words(input logic [63:0] addr, input logic [63:0] d);
        logic [511:0] ln;
        ln = merge_model(line_of(), int'(addr[5:0]), d);
        exp_q.push_back('{tag: RD_TAG, dat: {addr[63:6], 6'b0}});
        exp_q.push_back('{tag: WR_TAG, dat: {addr[63:6], 6'b0}});
        for (int k = 0; k < 8; k++) exp_q.push_back('{tag: WR_TAG, dat: ln[64*k +: 64]});
    endtask

    task automatic set_line(input logic [63:0] base, input logic [63:0] step);
        for (int k = 0; k < 8; k++) mem_line[k] = base + 64'(k) * step;
    endtask

    task automatic wait_load_done(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (load_done) ok = 1'b1;
        end
        if (!ok) chk({name, " load_done timeout"}, 64'(load_done), 64'd1);
    endtask

    task automatic wait_store_fall(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (!store_opn) ok = 1'b1;
        end
        if (!ok) chk({name, " store_opn fall timeout"}, 64'(store_opn), 64'd0);
    endtask

    // Bus model: drives read beats (plus occasional foreign-tag beats), randomly stalls requests, scores accepted words.
    always @(negedge clk) begin
        bit    ack_en;
        word_t w;
        bus_respcyc = 1'b0;
        bus_resptag = '0;
        bus_resp    = '0;
        if (!no_stall && $urandom_range(0, 7) == 0) begin
            bus_respcyc = 1'b1;
            bus_resptag = ($urandom_range(0, 1) == 0) ? WR_TAG : 13'h0042;
            bus_resp    = {$urandom, $urandom};
        end else if (resp_q.size() > 0 && (no_stall || $urandom_range(0, 3) != 0)) begin
            bus_respcyc = 1'b1;
            bus_resptag = RD_TAG;
            bus_resp    = resp_q.pop_front();
            beats_driven++;
        end
        ack_en     = no_stall || ($urandom_range(0, 2) != 0);
        bus_reqack = bus_reqcyc && ack_en;
        if (bus_reqcyc) reqcyc_cycles++;
        if (bus_reqcyc && ack_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected bus request", {51'b0, bus_reqtag}, 64'd0);
            end else begin
                w = exp_q.pop_front();
                chk("bus_reqtag", {51'b0, bus_reqtag}, {51'b0, w.tag});
                chk("bus_req", bus_req, w.dat);
            end
            if (bus_reqtag == RD_TAG)
                for (int k = 0; k < 8; k++) resp_q.push_back(mem_line[k]);
        end
        #1;
        if (bus_respcyc) chk("bus_respack", 64'(bus_respack), 64'(bus_resptag == RD_TAG));
    end

    task automatic run_vec(input vec_t v, input string name);
        set_line(v.base, v.step);
        reqcyc_cycles = 0;
        if (!v.exp_err) begin
            if (v.is_store) push_store_words(v.addr, v.sdata);
            else exp_q.push_back('{tag: RD_TAG, dat: {v.addr[63:6], 6'b0}});
        end
        @(negedge clk);
        if (!v.is_store) begin
            data_reqFlag = 1'b1;
            data_reqAddr = v.addr;
            wait_load_done(name);
            chk({name, " err"}, 64'(err), 64'(v.exp_err));
            chk({name, " load_buffer"}, load_buffer, v.exp_buf);
            chk({name, " words left"}, 64'(exp_q.size()), 64'd0);
            repeat (3) @(negedge clk);
            chk({name, " load_done held"}, 64'(load_done), 64'd1);
            chk({name, " load_buffer held"}, load_buffer, v.exp_buf);
            data_reqFlag = 1'b0;
            @(negedge clk);
            chk({name, " load_done clear"}, 64'(load_done), 64'd0);
        end else begin
            store_reqFlag = 1'b1;
            store_reqAddr = v.addr;
            store_data    = v.sdata;
            @(negedge clk);
            chk({name, " store_opn start"}, 64'(store_opn), 64'(!v.exp_err));
            if (!v.exp_err) wait_store_fall(name);
            chk({name, " err"}, 64'(err), 64'(v.exp_err));
            chk({name, " words left"}, 64'(exp_q.size()), 64'd0);
            repeat (3) @(negedge clk);
            chk({name, " no retrigger"}, 64'(store_opn), 64'd0);
            store_reqFlag = 1'b0;
            @(negedge clk);
        end
        chk({name, " err clear"}, 64'(err), 64'd0);
        if (v.exp_err) chk({name, " bus idle"}, 64'(reqcyc_cycles), 64'd0);
    endtask

    initial begin
        int b0;
        bit ok;
        vecs[0] = '{addr: 64'h1000, is_store: 0, sdata: 0, base: 0, step: PAT1, exp_err: 0, exp_buf: 0};
        vecs[1] = '{addr: 64'h1005, is_store: 0, sdata: 0, base: 64'h0001_0203_0405_0607,
                    step: 64'h0808_0808_0808_0808, exp_err: 0, exp_buf: 64'h0B0C_0D0E_0F00_0102};
        vecs[2] = '{addr: 64'h1038, is_store: 0, sdata: 0, base: 0, step: PAT1, exp_err: 0,
                    exp_buf: 64'h7777_7777_7777_7777};
        vecs[3] = '{addr: 64'h303C, is_store: 0, sdata: 0, base: 0, step: PAT1, exp_err: 1, exp_buf: 0};
        vecs[4] = '{addr: 64'h1008, is_store: 0, sdata: 0, base: 0, step: PAT1, exp_err: 0, exp_buf: PAT1};
        vecs[5] = '{addr: 64'h100C, is_store: 0, sdata: 0, base: 0, step: PAT1, exp_err: 0,
                    exp_buf: 64'h2222_2222_1111_1111};
        vecs[6] = '{addr: 64'h2010, is_store: 1, sdata: 64'hAABB_CCDD_EEFF_0011, base: 0, step: 0,
                    exp_err: 0, exp_buf: 0};
        vecs[7] = '{addr: 64'h2003, is_store: 1, sdata: 64'h0102_0304_0506_0708,
                    base: 64'h1000_0000_0000_0000, step: 64'h0101_0101_0101_0101, exp_err: 0, exp_buf: 0};
        vecs[8] = '{addr: 64'h207D, is_store: 1, sdata: 64'h5555_5555_5555_5555, base: 0, step: 0,
                    exp_err: 1, exp_buf: 0};
        vecs[9] = '{addr: 64'h1039, is_store: 0, sdata: 0, base: 0, step: PAT1, exp_err: 1, exp_buf: 0};
        set_line(0, 0);

        repeat (2) @(negedge clk);
        chk("reset load_done", 64'(load_done), 64'd0);
        chk("reset load_buffer", load_buffer, 64'd0);
        chk("reset store_opn", 64'(store_opn), 64'd0);
        chk("reset err", 64'(err), 64'd0);
        chk("reset bus_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("reset bus_req", bus_req, 64'd0);
        chk("reset bus_reqtag", {51'b0, bus_reqtag}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Unstalled load: load_done must appear in the 11th cycle counted from the IDLE cycle.
        no_stall = 1'b1;
        set_line(64'h0F0E_0D0C_0B0A_0908, 64'd1);
        exp_q.push_back('{tag: RD_TAG, dat: 64'h4000});
        @(negedge clk);
        data_reqFlag = 1'b1;
        data_reqAddr = 64'h4000;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 9) chk("latency early", 64'(load_done), 64'd0);
        end
        chk("latency on time", 64'(load_done), 64'd1);
        chk("latency data", load_buffer, 64'h0F0E_0D0C_0B0A_0908);
        data_reqFlag = 1'b0;
        @(negedge clk);
        no_stall = 1'b0;

        // Both flags at once: the load completes before the store touches the bus.
        set_line(0, PAT1);
        exp_q.push_back('{tag: RD_TAG, dat: 64'h1000});
        @(negedge clk);
        data_reqFlag  = 1'b1;
        data_reqAddr  = 64'h1008;
        store_reqFlag = 1'b1;
        store_reqAddr = 64'h2010;
        store_data    = 64'hDEAD_BEEF_CAFE_F00D;
        wait_load_done("both");
        chk("both load_buffer", load_buffer, PAT1);
        chk("both store waits", 64'(store_opn), 64'd0);
        chk("both words left", 64'(exp_q.size()), 64'd0);
        push_store_words(64'h2010, 64'hDEAD_BEEF_CAFE_F00D);
        data_reqFlag = 1'b0;
        @(negedge clk);
        chk("both load_done clear", 64'(load_done), 64'd0);
        @(negedge clk);
        chk("both store start", 64'(store_opn), 64'd1);
        wait_store_fall("both");
        chk("both store words left", 64'(exp_q.size()), 64'd0);
        store_reqFlag = 1'b0;
        @(negedge clk);

        // Reset during RD_RESP after three beats; the rest are drained, then a fresh load must be clean.
        no_stall = 1'b1;
        set_line(0, PAT1);
        exp_q.push_back('{tag: RD_TAG, dat: 64'h1000});
        b0 = beats_driven;
        @(negedge clk);
        data_reqFlag = 1'b1;
        data_reqAddr = 64'h1000;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(posedge clk);
            #1;
            if (beats_driven - b0 == 3) ok = 1'b1;
        end
        chk("rst three beats seen", 64'(ok), 64'd1);
        reset = 1'b1;
        data_reqFlag = 1'b0;
        #1;
        chk("rst bus_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("rst load_done", 64'(load_done), 64'd0);
        chk("rst store_opn", 64'(store_opn), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (resp_q.size() == 0) ok = 1'b1;
        end
        chk("rst drain", 64'(resp_q.size()), 64'd0);
        chk("rst drained beats", 64'(beats_driven - b0), 64'd8);
        repeat (2) @(negedge clk);
        chk("rst no load_done", 64'(load_done), 64'd0);
        no_stall = 1'b0;
        run_vec('{addr: 64'h1000, is_store: 0, sdata: 0, base: 64'hDEAD_BEEF_0000_0000, step: 64'd1,
                  exp_err: 0, exp_buf: 64'hDEAD_BEEF_0000_0000}, "post-reset");

        repeat (4) @(negedge clk);
        chk("final words left", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (%0d tests so far)", n_tests);
        $fatal(1);
    end
endmodule
